word_feeder: RTL



---
 rtl/word_feeder.sv | 118 +++++++++++
 1 files changed

// File: rtl/word_feeder.sv
// word_feeder: splits a byte stream into null-padded words and runs one matcher lookup per word (lookup timeout under WORD_FEEDER_TIMEOUT_EN)
module word_feeder #(
  parameter int WORD_LENGTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] DELIM = 8'h20,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic in_last,
  output logic [WORD_LENGTH*DATA_WIDTH-1:0] word_o,
  output logic cs_o,
  input  logic match_done_i,
  input  logic match_found_i,
  output logic res_valid,
  input  logic res_ready,
  output logic res_found,
  output logic res_trunc,
  output logic res_timeout,
  output logic [CNT_WIDTH-1:0] words_total,
  output logic [CNT_WIDTH-1:0] words_found
);
  localparam int CW = $clog2(WORD_LENGTH+1);
  typedef enum logic [1:0] {COLLECT, MATCH, REPORT} state_t;
  state_t state_q, state_d;
  logic [WORD_LENGTH*DATA_WIDTH-1:0] word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] total_q, total_d, hits_q, hits_d;
  logic trunc_q, trunc_d, res_found_q, res_found_d, res_timeout_q, res_timeout_d;
  logic in_ready_q, cs_q, res_valid_q, res_trunc_q;
  logic delim, expired;
`ifdef WORD_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] tmr_q, tmr_d;
  assign expired = tmr_q == TW'(TIMEOUT_CYCLES-1);
  assign tmr_d = (state_q == MATCH && state_d == MATCH) ? tmr_q + 1'b1 : '0;
  always_ff @(posedge clk) tmr_q <= rst ? '0 : tmr_d;
`else
  assign expired = 1'b0;
`endif
  always_comb begin
    delim = in_data == DELIM;
    state_d = state_q;
    word_d = word_q;
    cnt_d = cnt_q;
    trunc_d = trunc_q;
    res_found_d = res_found_q;
    res_timeout_d = res_timeout_q;
    total_d = total_q;
    hits_d = hits_q;
    if (state_q == COLLECT && in_valid && in_ready_q) begin
      if (!delim && cnt_q < CW'(WORD_LENGTH)) begin
        for (int i = 0; i < WORD_LENGTH; i++)
          if (cnt_q == CW'(i)) word_d[(WORD_LENGTH-1-i)*DATA_WIDTH +: DATA_WIDTH] = in_data;
        cnt_d = cnt_q + 1'b1;
      end
      trunc_d = trunc_q | (!delim && cnt_q == CW'(WORD_LENGTH));
      state_d = (cnt_d != '0 && (delim || in_last)) ? MATCH : COLLECT;
    end
    if (state_q == MATCH && (match_done_i || expired)) begin
      state_d = REPORT;
      res_found_d = match_done_i & match_found_i;
      res_timeout_d = !match_done_i;
      total_d = total_q + {{(CNT_WIDTH-1){1'b0}}, ~&total_q};
      hits_d = hits_q + {{(CNT_WIDTH-1){1'b0}}, match_done_i & match_found_i & ~&hits_q};
    end
    if (state_q == REPORT && res_ready) begin
      state_d = COLLECT;
      word_d = '0;
      cnt_d = '0;
      trunc_d = 1'b0;
      res_found_d = 1'b0;
      res_timeout_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      word_q <= '0;
      cnt_q <= '0;
      trunc_q <= 1'b0;
      res_found_q <= 1'b0;
      res_timeout_q <= 1'b0;
      total_q <= '0;
      hits_q <= '0;
      in_ready_q <= 1'b0;
      cs_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      cnt_q <= cnt_d;
      trunc_q <= trunc_d;
      res_found_q <= res_found_d;
      res_timeout_q <= res_timeout_d;
      total_q <= total_d;
      hits_q <= hits_d;
      in_ready_q <= state_d == COLLECT;
      cs_q <= state_d == MATCH;
      res_valid_q <= state_d == REPORT;
      res_trunc_q <= state_d == REPORT && trunc_d;
    end
  end
  assign in_ready = in_ready_q;
  assign word_o = word_q;
  assign cs_o = cs_q;
  assign res_valid = res_valid_q;
  assign res_found = res_found_q;
  assign res_trunc = res_trunc_q;
  assign res_timeout = res_timeout_q;
  assign words_total = total_q;
  assign words_found = hits_q;
endmodule
